// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_pkg
//  Description : Shared definitions for the bit-serial magnitude comparator.
//                Holds the FSM state encoding, the result-select encoding
//                and a helper that maps one bit-pair decision onto a
//                result select.
//  Revision    : 1.0  initial release
// ============================================================================
package comparator_pkg;

  // FSM state encoding (explicit 2-bit width)
  typedef logic [1:0] state_t;
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_SCAN = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // Result select held in the result register. c_RES_NONE is the reset
  // value, which decodes to all flags low until a first result exists.
  typedef logic [1:0] res_sel_t;
  localparam logic [1:0] c_RES_NONE = 2'd0;
  localparam logic [1:0] c_RES_EQ   = 2'd1;
  localparam logic [1:0] c_RES_LT   = 2'd2;
  localparam logic [1:0] c_RES_GT   = 2'd3;

  // Maps a decided bit pair (bits differ) onto LT/GT.
  function automatic res_sel_t f_decide(input logic i_gt);
    return i_gt ? c_RES_GT : c_RES_LT;
  endfunction

endpackage : comparator_pkg
`default_nettype wire

// File: rtl/bit_compare_cell.sv
`default_nettype none
// ============================================================================
//  Module      : bit_compare_cell
//  Description : Single bit-pair decision element. Reports whether the two
//                bits differ and, if so, whether A wins. The i_invert input
//                flips the winner, which is what the sign bit needs in
//                two's-complement mode (a 1 there means negative).
//  Ports       : i_a_bit  - bit of operand A at the current index
//                i_b_bit  - bit of operand B at the current index
//                i_invert - swap the sense of the greater-than decision
//                o_diff   - bits differ (decision is final)
//                o_gt     - A greater than B at this bit (valid with o_diff)
//  Revision    : 1.0  initial release
// ============================================================================
module bit_compare_cell (
  input  logic i_a_bit,
  input  logic i_b_bit,
  input  logic i_invert,
  output logic o_diff,
  output logic o_gt
);

  logic w_diff;
  logic w_gt_raw;

  assign w_diff   = i_a_bit ^ i_b_bit;
  assign w_gt_raw = i_a_bit & ~i_b_bit;

  assign o_diff = w_diff;
  // Only meaningful when the bits differ; gating keeps it clean otherwise.
  assign o_gt   = w_diff & (w_gt_raw ^ i_invert);

endmodule : bit_compare_cell
`default_nettype wire

// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : serial_comparator
//  Description : Bit-serial magnitude comparator. Captures two WIDTH-bit
//                operands on start, then walks them MSB first one bit pair
//                per cycle, stopping at the first differing pair. Supports
//                unsigned and two's-complement compare.
//  Parameters  : WIDTH       - operand width, 2..32
//  Ports       : clk         - clock, rising edge
//                reset       - synchronous active-high reset
//                start       - begin a comparison (accepted in IDLE/DONE)
//                signed_mode - 0 unsigned, 1 two's complement
//                a, b        - operands, captured with start
//                busy        - comparison in progress
//                done        - one-cycle pulse, results valid
//                eq/neq/lt/gt- result flags, held until next result/reset
//  Revision    : 1.0  initial release
// ============================================================================
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             neq,
  output logic             lt,
  output logic             gt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] c_MSB_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE = IDX_W'(1);

  state_t           r_state;
  res_sel_t         r_res;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;

  logic w_a_bit;
  logic w_b_bit;
  logic w_invert;
  logic w_diff;
  logic w_gt;
  logic w_accept;
  logic w_last;

  // Operand bits at the current scan index feed the single decision cell.
  assign w_a_bit  = r_a[r_idx];
  assign w_b_bit  = r_b[r_idx];
  // Only the sign bit flips its meaning in two's-complement mode.
  assign w_invert = r_signed & (r_idx == c_MSB_IDX);
  assign w_last   = (r_idx == '0);
  assign w_accept = start & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));

  bit_compare_cell u_cell (
    .i_a_bit  (w_a_bit),
    .i_b_bit  (w_b_bit),
    .i_invert (w_invert),
    .o_diff   (w_diff),
    .o_gt     (w_gt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_ST_IDLE;
      r_res    <= c_RES_NONE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_idx    <= c_MSB_IDX;
            r_state  <= c_ST_SCAN;
          end else begin
            r_state  <= c_ST_IDLE;
          end
        end

        c_ST_SCAN: begin
          // Results change only here, on the transition into DONE.
          if (w_diff) begin
            r_res   <= f_decide(w_gt);
            r_state <= c_ST_DONE;
          end else if (w_last) begin
            r_res   <= c_RES_EQ;
            r_state <= c_ST_DONE;
          end else begin
            r_idx   <= r_idx - c_IDX_ONE;
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == c_ST_SCAN);
  assign done = (r_state == c_ST_DONE);

  // Flags decode from the held result; c_RES_NONE leaves all four low.
  assign eq  = (r_res == c_RES_EQ);
  assign lt  = (r_res == c_RES_LT);
  assign gt  = (r_res == c_RES_GT);
  assign neq = lt | gt;

endmodule : serial_comparator
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_comparator
//  Description : Directed self-checking bench for serial_comparator, WIDTH=5.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_comparator;

  localparam int W = 5;

  // Flag patterns as {eq, neq, lt, gt}
  localparam logic [3:0] c_F_NONE = 4'b0000;
  localparam logic [3:0] c_F_EQ   = 4'b1000;
  localparam logic [3:0] c_F_LT   = 4'b0110;
  localparam logic [3:0] c_F_GT   = 4'b0101;

  logic         clk;
  logic         reset;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         neq;
  logic         lt;
  logic         gt;

  int n_tests = 0;
  int n_fail  = 0;

  serial_comparator #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .neq         (neq),
    .lt          (lt),
    .gt          (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, eq, neq, lt, gt}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge, then scrambles the inputs
  // so any late sampling of a/b/signed_mode would corrupt the result.
  // Returns just after edge 0, i.e. in cycle 1.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm);
    a           = ia;
    b           = ib;
    signed_mode = sm;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    a           = ~ia;
    b           = ib ^ 5'b10110;
    signed_mode = ~sm;
  endtask

  // Steps until done, counting cycles from first_cyc; bounded.
  task automatic wait_done(input string tag, input int first_cyc, input int exp_cyc);
    int cyc;
    cyc = first_cyc;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check(tag, cyc, exp_cyc);
  endtask

  task automatic run(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic sm, input int exp_cyc, input logic [3:0] exp_flags);
    start_op(ia, ib, sm);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done({tag, "_cycle"}, 1, exp_cyc);
    check_flags({tag, "_flags"}, exp_flags);
    tick();
    check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    reset       = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    tick();
    tick();
    check("reset_ctl", {30'd0, busy, done}, 32'd0);
    check_flags("reset_flags", c_F_NONE);
    reset = 1'b0;
    tick();

    // Unsigned / signed directed vectors
    run("eq_1_1",      5'b00001, 5'b00001, 1'b0, 6, c_F_EQ);
    run("u_early_gt",  5'b10101, 5'b01010, 1'b0, 2, c_F_GT);
    run("s_early_lt",  5'b10101, 5'b01010, 1'b1, 2, c_F_LT);
    run("s_bit2_gt",   5'b00101, 5'b00011, 1'b1, 4, c_F_GT);
    run("u_bit2_lt",   5'b00011, 5'b00101, 1'b0, 4, c_F_LT);
    run("s_m1_vs_m2",  5'b11111, 5'b11110, 1'b1, 6, c_F_GT);
    run("s_15_vs_m16", 5'b01111, 5'b10000, 1'b1, 2, c_F_GT);

    // start mid-SCAN is ignored; flags hold the previous GT until done
    start_op(5'b00001, 5'b00001, 1'b0);
    tick();
    a     = 5'b11111;
    b     = 5'b00000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    check_flags("ign_hold", c_F_GT);
    wait_done("ign_cycle", 3, 6);
    check_flags("ign_flags", c_F_EQ);
    tick();

    // Back-to-back: start presented during the DONE cycle
    start_op(5'b10101, 5'b01010, 1'b0);
    wait_done("b2b1_cycle", 1, 2);
    check_flags("b2b1_flags", c_F_GT);
    start_op(5'b00011, 5'b00101, 1'b0);
    check("b2b2_busy", {30'd0, busy, done}, 32'd2);
    wait_done("b2b2_cycle", 1, 4);
    check_flags("b2b2_flags", c_F_LT);
    tick();

    // Reset abort in cycle 3, with start also high to show reset wins
    start_op(5'b11111, 5'b11111, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("abort_ctl", {30'd0, busy, done}, 32'd0);
    check_flags("abort_flags", c_F_NONE);
    reset = 1'b0;
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    check("abort_quiet", seen, 0);
    run("post_reset", 5'b10101, 5'b01010, 1'b0, 2, c_F_GT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_comparator
`default_nettype wire

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  request to begin a comparison; sampled only in IDLE or DONE.
REQ-005 Port: signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; captured with start.
REQ-006 Port: a  input  WIDTH  operand A; captured with start.
REQ-007 Port: b  input  WIDTH  operand B; captured with start.
REQ-008 Port: busy  output  1  high while a comparison is in progress (SCAN state).
REQ-009 Port: done  output  1  one-cycle pulse marking valid results.
REQ-010 Port: eq  output  1  A == B.
REQ-011 Port: neq  output  1  A != B; always the complement of eq once a result exists.
REQ-012 Port: lt  output  1  A < B under the captured mode.
REQ-013 Port: gt  output  1  A > B under the captured mode.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-015 In IDLE or DONE with start=1, the block SHALL capture a, b and signed_mode, load the bit index with WIDTH-1, and enter SCAN on the next edge.
REQ-016 In SCAN, each cycle SHALL compare exactly one bit pair, MSB first, at the current index.
REQ-017 If the bits differ, the result SHALL be decided in that cycle (early termination) and the FSM SHALL enter DONE.
REQ-018 Unsigned decision: a[i]=1 gives gt; a[i]=0 gives lt.
REQ-019 Signed decision at index WIDTH-1 SHALL be inverted (a[MSB]=1 gives lt); lower bits SHALL follow REQ-018.
REQ-020 If the bits are equal at index 0, the result SHALL be eq and the FSM SHALL enter DONE; otherwise the index SHALL decrement by one.
REQ-021 Latency: with start sampled at edge 0 and the first differing bit at position k, done SHALL be high during cycle (WIDTH-k)+1; for equal operands, during cycle WIDTH+1.
REQ-022 In DONE, done SHALL be high for exactly that cycle; without start the FSM SHALL return to IDLE.
REQ-023 eq, neq, lt and gt SHALL be updated only on entry to DONE, and SHALL hold until the next entry to DONE or reset.
REQ-024 After the first result, exactly one of eq, lt, gt SHALL be high, and neq SHALL equal ~eq.
REQ-025 start during SCAN SHALL be ignored; operand changes during SCAN SHALL NOT affect the result.
REQ-026 start in DONE SHALL be accepted (back-to-back operation), with no idle cycle between comparisons.
REQ-027 busy SHALL equal (state == SCAN).

Reset
REQ-028 When reset=1, the FSM SHALL enter IDLE on that edge, and busy, done, eq, neq, lt and gt SHALL all be 0.
REQ-029 Reset asserted during SCAN or DONE SHALL abort the operation with no done pulse; reset SHALL take priority over start.

Structure
REQ-030 The state encoding (IDLE, SCAN, DONE) and the result-select constants SHALL live in shared package comparator_pkg.
REQ-031 The per-bit decision (inequality via XOR plus the greater-than bit) SHALL be a sub-module bit_compare_cell, instantiated once and fed by the indexed bits.
REQ-032 The bit index width SHALL be $clog2(WIDTH); the implementation SHALL contain no WIDTH-wide comparator.

Verification (WIDTH=5)
REQ-033 Equal operands: start with a=00001, b=00001, unsigned -> done in cycle 6, eq=1, neq=0, lt=0, gt=0.
REQ-034 Early termination: start with a=10101, b=01010, unsigned -> done in cycle 2, gt=1, neq=1.
REQ-035 Signed mode: start with a=10101 (-11), b=01010 (+10), signed_mode=1 -> done in cycle 2, lt=1; a=00101, b=00011 -> difference at bit 2, done in cycle 4, gt=1.
REQ-036 Ignore and back-to-back: start again mid-SCAN with new operands -> ignored and result unchanged; start held high in DONE -> next SCAN begins the following cycle and busy shows no gap.
REQ-037 Reset abort: reset asserted in cycle 3 of a=11111 vs b=11111 -> no done pulse, all outputs 0, state IDLE; a new start afterwards completes normally.
